// File: rtl/gpio_in_conditioner.sv
// Switch input conditioning: per-bit 2-FF sync, tick-based debounce, edge pulses, sticky flags.
// Optional GPIO_COND_IRQ_EN adds IRQ_MASK and a registered irq_o summarizing masked evt_o.

module gpio_in_conditioner_lane #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  input  logic tick,
  input  logic clr,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic evt
);
  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          s1, s2;
  logic [CW-1:0] c;
  logic          accept;

  assign accept = (s2 != stable) && tick && (c == CW'(DEB_TICKS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      c      <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      evt    <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any agreeing cycle restarts qualification; off-tick disagreement holds c.
      if (s2 == stable) begin
        c <= '0;
      end else if (tick) begin
        if (accept) begin
          stable <= s2;
          c      <= '0;
        end else begin
          c <= c + 1'b1;
        end
      end
      rise <= accept & s2;
      fall <= accept & ~s2;
      // Set from the registered pulses wins over a simultaneous clear.
      evt  <= (evt & ~clr) | rise | fall;
    end
  end
endmodule

module gpio_in_conditioner #(
  parameter int WIDTH     = 16,
  parameter int TICK_DIV  = 100000,
  parameter int DEB_TICKS = 10
`ifdef GPIO_COND_IRQ_EN
  ,
  parameter logic [WIDTH-1:0] IRQ_MASK = {WIDTH{1'b1}}
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
  input  logic [WIDTH-1:0] evt_clr_i
`ifdef GPIO_COND_IRQ_EN
  ,
  output logic             irq_o
`endif
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // One prescaler shared by every channel keeps all lanes on the same tick phase.
  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_in_conditioner_lane #(.DEB_TICKS(DEB_TICKS)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw    (raw_i[i]),
      .tick   (tick),
      .clr    (evt_clr_i[i]),
      .stable (stable_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i]),
      .evt    (evt_o[i])
    );
  end

`ifdef GPIO_COND_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_o <= 1'b0;
    else         irq_o <= |(evt_o & IRQ_MASK);
  end
`endif
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with TICK_DIV=4, DEB_TICKS=3, WIDTH=16.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_gpio_in_conditioner;
  localparam int WIDTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] raw_i;
  logic [WIDTH-1:0] stable_o, rise_o, fall_o, evt_o;
  logic [WIDTH-1:0] evt_clr_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

`ifdef GPIO_COND_IRQ_EN
  logic irq_o;
  gpio_in_conditioner #(.WIDTH(WIDTH), .TICK_DIV(4), .DEB_TICKS(3), .IRQ_MASK(16'h0001)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(raw_i), .stable_o(stable_o), .rise_o(rise_o),
    .fall_o(fall_o), .evt_o(evt_o), .evt_clr_i(evt_clr_i), .irq_o(irq_o));
`else
  gpio_in_conditioner #(.WIDTH(WIDTH), .TICK_DIV(4), .DEB_TICKS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(raw_i), .stable_o(stable_o), .rise_o(rise_o),
    .fall_o(fall_o), .evt_o(evt_o), .evt_clr_i(evt_clr_i));
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_pulse(input logic [WIDTH-1:0] m);
    evt_clr_i = m;
    @(negedge clk_i);
    evt_clr_i = '0;
  endtask

  initial begin
    int lat, cnt, at;
    logic s_st, s_rs, s_ev;

    // Reset with all switches high: outputs stay 0, then a normal rise is accepted.
    rst_ni = 1'b0; raw_i = 16'hFFFF; evt_clr_i = '0;
    repeat (5) @(negedge clk_i);
    chk("rst_stable", stable_o, 0);
    chk("rst_rise",   rise_o,   0);
    chk("rst_fall",   fall_o,   0);
    chk("rst_evt",    evt_o,    0);
    rst_ni = 1'b1;
    lat = 0;
    while (stable_o != 16'hFFFF && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    chk("rst_accept_lat", lat, 12);
    chk("rst_rise_pulse", rise_o, 16'hFFFF);
    @(negedge clk_i);
    chk("rst_rise_end", rise_o, 0);
    chk("rst_evt_set",  evt_o, 16'hFFFF);

    // Reset again with switches low to get a clean all-zero baseline.
    rst_ni = 1'b0; raw_i = '0;
    @(negedge clk_i);
    chk("rst2_stable", stable_o, 0);
    chk("rst2_evt",    evt_o,    0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Glitch: 3-cycle pulse is shorter than a tick interval.
    s_st = 0; s_rs = 0; s_ev = 0;
    raw_i[3] = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk_i);
      s_st |= stable_o[3]; s_rs |= rise_o[3]; s_ev |= evt_o[3];
      if (i == 2) raw_i[3] = 1'b0;
    end
    chk("glitch_stable", s_st, 0);
    chk("glitch_rise",   s_rs, 0);
    chk("glitch_evt",    s_ev, 0);

    // Bounce: toggle bit 0 every 5 cycles for 40 cycles, then hold high.
    cnt = 0; at = -1;
    for (int i = 0; i < 70; i++) begin
      raw_i[0] = (i >= 40) ? 1'b1 : (((i / 5) % 2) == 0);
      @(negedge clk_i);
      if (rise_o[0]) begin
        cnt++;
        at = i - 40 + 1;
      end
    end
    chk("bounce_pulses", cnt, 1);
    chk("bounce_lat_ok", (at >= 9 && at <= 14), 1);

    // Fall + clear on bit 5.
    raw_i[5] = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("fall_pre_stable", stable_o[5], 1);
    clr_pulse(16'h0020);
    @(negedge clk_i);
    chk("fall_pre_evt", evt_o[5], 0);
    raw_i[5] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (fall_o[5]) cnt++;
    end
    chk("fall_pulses", cnt, 1);
    chk("fall_stable", stable_o[5], 0);
    chk("fall_evt",    evt_o[5], 1);
    clr_pulse(16'h0020);
    chk("clr_evt5", evt_o[5], 0);
    clr_pulse(16'h0020);
    chk("clr_zero_noop", evt_o[5], 0);

    // Set/clear collision on bit 7: clear lands in the same cycle as the rise pulse.
    raw_i[7] = 1'b1;
    cnt = 0;
    while (!rise_o[7] && cnt < 30) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("coll_rise_seen", rise_o[7], 1);
    clr_pulse(16'h0080);
    chk("coll_evt7", evt_o[7], 1);

`ifdef GPIO_COND_IRQ_EN
    clr_pulse(16'hFFFF);
    @(negedge clk_i);
    chk("irq_idle", irq_o, 0);
    raw_i[1] = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("irq_evt1", evt_o[1], 1);
    chk("irq_masked", irq_o, 0);
    raw_i[0] = 1'b0;
    cnt = 0;
    while (!evt_o[0] && cnt < 30) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("irq_evt0", evt_o[0], 1);
    chk("irq_lag0", irq_o, 0);
    @(negedge clk_i);
    chk("irq_set", irq_o, 1);
    clr_pulse(16'h0001);
    chk("irq_evt0_clr", evt_o[0], 0);
    chk("irq_lag1", irq_o, 1);
    @(negedge clk_i);
    chk("irq_clr", irq_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
